// File: rtl/pwm_multi_if.sv
// Duty-word handshake between the signal mixer (master) and the PWM block (slave).
// Channel i of duty_in occupies bits [i*WIDTH +: WIDTH].
interface pwm_multi_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] duty_in;
    logic                      duty_valid;
    logic                      duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared up / up-down counter, per-channel
// double-buffered duty words that only take effect at a period boundary.

// Per-channel registered compare. Low whenever the counter is not running.
module pwm_multi_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm
);
    // Output register: one cycle behind the counter value it was compared against.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) pwm <= 1'b0;
        else        pwm <= en && (cnt < duty);
    end
endmodule

module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic                mode,
    pwm_multi_if.slave          dif,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             dir, dir_nxt;
    logic             mode_q;
    logic             pending;
    logic             boundary, accept, consume;
    logic [CHANNELS-1:0][WIDTH-1:0] active, shadow, active_nxt;

    assign boundary         = en && (cnt == '0);
    assign period_start     = boundary;
    assign dif.duty_ready   = !pending;
    assign accept           = dif.duty_valid && !pending;
    // While stopped the shadow word drains straight away so the first enabled
    // period already uses it.
    assign consume          = pending && (boundary || !en);
    // The compare at cnt==0 must already see the word being promoted this
    // cycle, otherwise the first output cycle of a period would use stale duty.
    assign active_nxt       = consume ? shadow : active;

    // Next counter value: wrap in edge mode, bounce between 0 and MAX in center mode.
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        dir_nxt = 1'b0;
        if (mode_q) begin
            cnt_nxt = dir ? (cnt - 1'b1) : (cnt + 1'b1);
            dir_nxt = dir;
            if (cnt_nxt == MAX)     dir_nxt = 1'b1;
            else if (cnt_nxt == '0) dir_nxt = 1'b0;
        end
    end

    // Counter, direction and mode latch; mode only changes at a boundary or while stopped.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt    <= '0;
            dir    <= 1'b0;
            mode_q <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            dir    <= 1'b0;
            mode_q <= mode;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (boundary) mode_q <= mode;
        end
    end

    // Double buffer: accept into shadow when free, promote to active at a boundary.
    // A word accepted on the boundary itself waits for the following one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (consume) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (accept) begin
            shadow  <= dif.duty_in;
            pending <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_multi_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .n_rst(n_rst),
            .en   (en),
            .cnt  (cnt),
            .duty (active_nxt[i]),
            .pwm  (pwm_out[i])
        );
    end
endmodule
